// File: rtl/sseg_scan_mux.sv
// Scan controller for common-anode seven-segment digits. It double-buffers the
// displayed value, blanks leading zeros and holds a guard interval with all anodes off.
module sseg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 1
) (
  input  logic                      CLK,
  input  logic                      RST_L,
  input  logic [4*NUM_DIGITS-1:0]   VALUE,
  input  logic                      LOAD,
  input  logic                      BLANK_LZ,
  output logic [3:0]                B,
  output logic [NUM_DIGITS-1:0]     AN_L,
  output logic                      UPD
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [3:0]            b_q, b_d;
  logic [NUM_DIGITS-1:0] an_l_q, an_l_d;
  logic                  upd_q, upd_d;

  logic                  tick;
  logic                  wrap;
  logic                  in_guard;
  logic                  zero_above;
  logic [NUM_DIGITS-1:0] blank;

  always_comb begin
    tick     = (cnt_q == CNT_LAST);
    wrap     = tick && (idx_q == IDX_LAST);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // A load on the wrap cycle still commits the old pend; the new value waits a frame.
    disp_d   = (wrap && pend_v_q) ? pend_q : disp_q;
    upd_d    = wrap && pend_v_q;
    pend_d   = LOAD ? VALUE : pend_q;
    pend_v_d = pend_v_q;
    if (LOAD)      pend_v_d = 1'b1;
    else if (wrap) pend_v_d = 1'b0;
  end

  // Digit i is blanked when it and every higher digit are zero; digit 0 never is.
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_q[4*i +: 4] == 4'h0);
      blank[i]   = BLANK_LZ && zero_above;
    end
  end

  always_comb begin
    in_guard = (cnt_q < GUARD_C);
    b_d      = 4'h0;
    an_l_d   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        b_d = disp_q[4*i +: 4];
        if (!in_guard && !blank[i]) an_l_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      b_q      <= 4'h0;
      an_l_q   <= '1;
      upd_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      b_q      <= b_d;
      an_l_q   <= an_l_d;
      upd_q    <= upd_d;
    end
  end

  assign B    = b_q;
  assign AN_L = an_l_q;
  assign UPD  = upd_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Scoreboard bench for sseg_scan_mux (4 digits, 8-cycle slots, 1 guard cycle).
// Expected per-cycle outputs are queued by cycle number; a monitor pops and compares.
module tb_sseg_scan_mux;
  logic        CLK = 1'b0;
  logic        RST_L = 1'b0;
  logic [15:0] VALUE = '0;
  logic        LOAD = 1'b0;
  logic        BLANK_LZ = 1'b0;
  logic [3:0]  B;
  logic [3:0]  AN_L;
  logic        UPD;

  int checks = 0;
  int failures = 0;
  int cyc;

  typedef struct {
    int         c;
    logic [3:0] b;
    logic [3:0] an;
    logic       upd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  sseg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(1)) dut (
    .CLK(CLK), .RST_L(RST_L), .VALUE(VALUE), .LOAD(LOAD), .BLANK_LZ(BLANK_LZ),
    .B(B), .AN_L(AN_L), .UPD(UPD)
  );

  always #5 CLK = ~CLK;

  // cyc = number of rising edges since reset release
  always @(posedge CLK or negedge RST_L)
    if (!RST_L) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got B=%h AN_L=%b UPD=%b, expected B=%h AN_L=%b UPD=%b",
               name, act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  // Frame f covers output cycles 32f+1..32f+32. bs/ans hold B and lit AN_L per slot
  // (nibble k = slot k); the first cycle of every slot is a guard cycle.
  task automatic push_frame(input int f, input logic [15:0] bs, input logic [15:0] ans,
                            input logic upd_end);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      for (int j = 1; j <= 8; j++) begin
        e.c   = 32*f + 8*k + j;
        e.b   = bs[4*k +: 4];
        e.an  = (j == 1) ? 4'b1111 : ans[4*k +: 4];
        e.upd = (k == 3 && j == 8) ? upd_end : 1'b0;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    int t = 0;
    while (cyc < n && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    if (cyc != n) begin
      checks++;
      failures++;
      $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_L) begin
      while (sb.size() > 0 && sb[0].c < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_cycle: expectation for cycle %0d not compared (now %0d)", sb[0].c, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].c == cyc) begin
        mon_e = sb.pop_front();
        check($sformatf("cyc%0d", cyc), {B, AN_L, UPD}, {mon_e.b, mon_e.an, mon_e.upd});
      end
    end
  end

  initial begin
    // Pre-phase: get a nonzero display, then reset asynchronously mid-slot.
    repeat (2) @(negedge CLK);
    RST_L = 1'b1;
    LOAD  = 1'b1;
    VALUE = 16'h9999;
    @(negedge CLK);
    LOAD  = 1'b0;
    wait_cyc(35);
    LOAD  = 1'b1;
    VALUE = 16'h7777;
    @(negedge CLK);
    LOAD  = 1'b0;
    wait_cyc(40);
    check("pre_reset", {B, AN_L, UPD}, {4'h9, 4'b1110, 1'b0});
    #2 RST_L = 1'b0;
    #1 check("async_reset", {B, AN_L, UPD}, {4'h0, 4'b1111, 1'b0});
    @(negedge CLK);
    check("reset_held", {B, AN_L, UPD}, {4'h0, 4'b1111, 1'b0});

    // Main run; the pending 7777 must have been discarded by the reset.
    RST_L = 1'b1;
    LOAD  = 1'b1;
    VALUE = 16'h1234;
    push_frame(0, 16'h0000, 16'h7BDE, 1'b1);
    push_frame(1, 16'h1234, 16'h7BDE, 1'b1);
    push_frame(2, 16'h0050, 16'hFFDE, 1'b1);
    push_frame(3, 16'h0000, 16'hFFFE, 1'b0);
    push_frame(4, 16'h0000, 16'h7BDE, 1'b1);
    push_frame(5, 16'hBEEF, 16'h7BDE, 1'b1);
    push_frame(6, 16'h1111, 16'h7BDE, 1'b1);
    push_frame(7, 16'h2222, 16'h7BDE, 1'b0);
    @(negedge CLK);
    LOAD  = 1'b0;
    VALUE = 16'hFFFF;

    wait_cyc(40);
    BLANK_LZ = 1'b1;
    LOAD  = 1'b1;
    VALUE = 16'h0050;
    @(negedge CLK);
    LOAD  = 1'b0;
    VALUE = 16'h8888;

    wait_cyc(70);
    LOAD  = 1'b1;
    VALUE = 16'h0000;
    @(negedge CLK);
    LOAD  = 1'b0;

    wait_cyc(128);
    BLANK_LZ = 1'b0;

    wait_cyc(135);
    LOAD  = 1'b1;
    VALUE = 16'hAAAA;
    @(negedge CLK);
    LOAD  = 1'b0;
    wait_cyc(150);
    LOAD  = 1'b1;
    VALUE = 16'hBEEF;
    @(negedge CLK);
    LOAD  = 1'b0;

    wait_cyc(169);
    LOAD  = 1'b1;
    VALUE = 16'h1111;
    @(negedge CLK);
    LOAD  = 1'b0;
    // 2222 is sampled on the frame-wrap edge 192
    wait_cyc(191);
    LOAD  = 1'b1;
    VALUE = 16'h2222;
    @(negedge CLK);
    LOAD  = 1'b0;
    VALUE = 16'h0000;

    wait_cyc(260);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
